// File: rtl/see_inject_ctrl_if.sv
// rtl/see_inject_ctrl_if.sv - host and cone-pair signal bundle for see_inject_ctrl
interface see_inject_ctrl_if #(
   parameter int NUM_IN    = 5,
   parameter int NUM_SITES = 5,
   parameter int CNT_W     = 16,
   parameter int SITE_W    = (NUM_SITES > 1) ? $clog2(NUM_SITES) : 1
);
   logic                 start;
   logic                 abort;
   logic                 golden_i;
   logic                 faulty_i;
   logic [NUM_IN-1:0]    vec_o;
   logic [NUM_SITES-1:0] fault_en_o;
   logic                 busy;
   logic                 done;
   logic                 err_valid;
   logic [SITE_W-1:0]    err_site;
   logic [NUM_IN-1:0]    err_vec;
   logic [CNT_W-1:0]     err_cnt;
   logic [CNT_W-1:0]     inj_cnt;

   modport master (
      output start, abort, golden_i, faulty_i,
      input  vec_o, fault_en_o, busy, done, err_valid, err_site, err_vec, err_cnt, inj_cnt
   );

   modport slave (
      input  start, abort, golden_i, faulty_i,
      output vec_o, fault_en_o, busy, done, err_valid, err_site, err_vec, err_cnt, inj_cnt
   );
endinterface

// File: rtl/see_inject_ctrl.sv
// rtl/see_inject_ctrl.sv - exhaustive single-site fault injection campaign sequencer
module see_inject_ctrl #(
   parameter int NUM_IN     = 5,
   parameter int NUM_SITES  = 5,
   parameter int SETTLE_CYC = 2,
   parameter int PULSE_CYC  = 1,
   parameter int CNT_W      = 16
) (
   input  logic            CLK,
   input  logic            RSTB,
   see_inject_ctrl_if.slave bus
);
   localparam int SITE_W  = (NUM_SITES > 1) ? $clog2(NUM_SITES) : 1;
   localparam int TMR_MAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [NUM_IN-1:0] VEC_LAST  = '1;
   localparam logic [SITE_W-1:0] SITE_LAST = SITE_W'(NUM_SITES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0]  PULSE_LD  = TMR_W'(PULSE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_APPLY, S_SETTLE, S_INJECT, S_SAMPLE, S_NEXT, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_IN-1:0]    vec_q, vec_d;
   logic [SITE_W-1:0]    site_q, site_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [NUM_SITES-1:0] fault_en_q, fault_en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_valid_q, err_valid_d;
   logic [SITE_W-1:0]    err_site_q, err_site_d;
   logic [NUM_IN-1:0]    err_vec_q, err_vec_d;
   logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]     inj_cnt_q, inj_cnt_d;
   logic                 in_campaign;

   assign in_campaign = (state_q == S_APPLY)  || (state_q == S_SETTLE) ||
                        (state_q == S_INJECT) || (state_q == S_SAMPLE) ||
                        (state_q == S_NEXT);

   // State register and all registered outputs
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         site_q      <= '0;
         tmr_q       <= '0;
         fault_en_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_valid_q <= 1'b0;
         err_site_q  <= '0;
         err_vec_q   <= '0;
         err_cnt_q   <= '0;
         inj_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         site_q      <= site_d;
         tmr_q       <= tmr_d;
         fault_en_q  <= fault_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_valid_q <= err_valid_d;
         err_site_q  <= err_site_d;
         err_vec_q   <= err_vec_d;
         err_cnt_q   <= err_cnt_d;
         inj_cnt_q   <= inj_cnt_d;
      end
   end

   // Next-state sequencing; outputs are decoded from the next state so they stay registered
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      site_d      = site_q;
      tmr_d       = tmr_q;
      err_valid_d = 1'b0;
      err_site_d  = err_site_q;
      err_vec_d   = err_vec_q;
      err_cnt_d   = err_cnt_q;
      inj_cnt_d   = inj_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               err_cnt_d = '0;
               inj_cnt_d = '0;
               vec_d     = '0;
               site_d    = '0;
               state_d   = S_APPLY;
            end
         end
         S_APPLY: begin
            tmr_d   = SETTLE_LD;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (tmr_q == '0) begin
               tmr_d   = PULSE_LD;
               state_d = S_INJECT;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_INJECT: begin
            if (tmr_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_SAMPLE: begin
            if (inj_cnt_q != CNT_MAX) inj_cnt_d = inj_cnt_q + 1'b1;
            if (bus.golden_i != bus.faulty_i) begin
               if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
               err_valid_d = 1'b1;
               err_site_d  = site_q;
               err_vec_d   = vec_q;
            end
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (site_q != SITE_LAST) begin
               site_d  = site_q + 1'b1;
               tmr_d   = SETTLE_LD;
               state_d = S_SETTLE;
            end else begin
               site_d = '0;
               if (vec_q == VEC_LAST) begin
                  state_d = S_DONE;
               end else begin
                  vec_d   = vec_q + 1'b1;
                  state_d = S_APPLY;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort freezes counters and error capture at their partial values
      if (bus.abort && in_campaign) begin
         state_d     = S_IDLE;
         vec_d       = vec_q;
         site_d      = site_q;
         err_valid_d = 1'b0;
         err_site_d  = err_site_q;
         err_vec_d   = err_vec_q;
         err_cnt_d   = err_cnt_q;
         inj_cnt_d   = inj_cnt_q;
      end

      busy_d = (state_d == S_APPLY)  || (state_d == S_SETTLE) ||
               (state_d == S_INJECT) || (state_d == S_SAMPLE) ||
               (state_d == S_NEXT);
      done_d = (state_d == S_DONE);
      fault_en_d = ((state_d == S_INJECT) || (state_d == S_SAMPLE)) ?
                   (NUM_SITES'(1) << site_d) : '0;
   end

   assign bus.vec_o      = vec_q;
   assign bus.fault_en_o = fault_en_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err_valid  = err_valid_q;
   assign bus.err_site   = err_site_q;
   assign bus.err_vec    = err_vec_q;
   assign bus.err_cnt    = err_cnt_q;
   assign bus.inj_cnt    = inj_cnt_q;
endmodule

// File: tb/tb_see_inject_ctrl.sv
// tb/tb_see_inject_ctrl.sv - randomized self-checking bench for see_inject_ctrl
module tb_see_inject_ctrl;
   localparam int NUM_IN    = 5;
   localparam int NUM_SITES = 5;
   localparam int S         = 2;
   localparam int P         = 1;
   localparam int CNT_W     = 16;
   localparam int NVEC      = 1 << NUM_IN;
   localparam int BLK       = S + P + 2;
   localparam int VBLK      = 1 + NUM_SITES * BLK;
   localparam int NCYC      = NVEC * VBLK;

   logic CLK  = 1'b0;
   logic RSTB = 1'b0;
   always #5 CLK = ~CLK;

   see_inject_ctrl_if #(.NUM_IN(NUM_IN), .NUM_SITES(NUM_SITES), .CNT_W(CNT_W)) bus ();

   see_inject_ctrl #(
      .NUM_IN(NUM_IN), .NUM_SITES(NUM_SITES), .SETTLE_CYC(S), .PULSE_CYC(P), .CNT_W(CNT_W)
   ) dut (
      .CLK (CLK),
      .RSTB(RSTB),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int mode = 0;
   logic [NUM_SITES-1:0] tab [NVEC];

   // Cone pair: 0 tied, 1 site-2 sensitive, 2 always inverted, 3 random per-(vector,site) table
   always_comb begin
      logic g;
      g = (^(bus.vec_o & 5'b10110)) ^ (bus.vec_o[0] & bus.vec_o[3]);
      bus.golden_i = g;
      case (mode)
         1:       bus.faulty_i = g ^ bus.fault_en_o[2];
         2:       bus.faulty_i = ~g;
         3:       bus.faulty_i = g ^ (|(bus.fault_en_o & tab[bus.vec_o]));
         default: bus.faulty_i = g;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit mism(input int v, input int s);
      case (mode)
         1:       return (s == 2);
         2:       return 1'b1;
         3:       return tab[v][s];
         default: return 1'b0;
      endcase
   endfunction

   // Injections (and errors) completed before busy cycle j: each pair is sampled at a fixed slot
   function automatic void count_before(input int j, output int inj, output int err);
      inj = 0;
      err = 0;
      for (int v = 0; v < NVEC; v++)
         for (int s = 0; s < NUM_SITES; s++)
            if (v * VBLK + 1 + s * BLK + S + P < j) begin
               inj++;
               if (mism(v, s)) err++;
            end
   endfunction

   function automatic logic [63:0] exp_pack(input int j);
      int inj, err, v, r, q, o;
      logic bsy, dn, ev;
      logic [4:0] vv, fe, ev_vec;
      logic [2:0] ev_site;
      logic [15:0] inj16, err16;
      count_before(j, inj, err);
      inj16 = inj[15:0];
      err16 = err[15:0];
      ev = 1'b0; ev_site = '0; ev_vec = '0; fe = '0;
      if (j < NCYC) begin
         bsy = 1'b1; dn = 1'b0;
         v = j / VBLK; r = j % VBLK; vv = v[4:0];
         if (r > 0) begin
            q = (r - 1) / BLK; o = (r - 1) % BLK;
            if (o >= S && o <= S + P) fe = 5'(1 << q);
            if (o == S + P + 1 && mism(v, q)) begin
               ev = 1'b1; ev_site = q[2:0]; ev_vec = v[4:0];
            end
         end
      end else begin
         bsy = 1'b0; dn = (j == NCYC); vv = 5'(NVEC - 1);
      end
      return {11'd0, bsy, dn, vv, fe, ev, ev_site, ev_vec, inj16, err16};
   endfunction

   function automatic logic [63:0] obs_pack();
      return {11'd0, bus.busy, bus.done, bus.vec_o, bus.fault_en_o, bus.err_valid,
              bus.err_valid ? bus.err_site : 3'd0, bus.err_valid ? bus.err_vec : 5'd0,
              bus.inj_cnt, bus.err_cnt};
   endfunction

   function automatic logic [63:0] all_outs();
      return {11'd0, bus.busy, bus.done, bus.vec_o, bus.fault_en_o, bus.err_valid,
              bus.err_site, bus.err_vec, bus.inj_cnt, bus.err_cnt};
   endfunction

   // One campaign, compared cycle by cycle against the schedule; optional abort / mid-run start / reset
   task automatic run(input int m, input int abort_at, input int start_at, input int rst_at);
      int inj, err, seen;
      mode = m;
      if (m == 3) for (int v = 0; v < NVEC; v++) tab[v] = 5'($urandom);
      @(negedge CLK);
      bus.start = 1'b1;
      @(posedge CLK);
      for (int j = 0; j <= NCYC + 1; j++) begin
         @(negedge CLK);
         bus.start = 1'b0;
         bus.abort = 1'b0;
         check($sformatf("trace m%0d j%0d", m, j), obs_pack(), exp_pack(j));
         if (j == start_at) bus.start = 1'b1;
         if (j == abort_at) begin
            bus.abort = 1'b1;
            @(negedge CLK);
            bus.abort = 1'b0;
            count_before(j, inj, err);
            check("abort_busy", 64'(bus.busy), 64'd0);
            check("abort_fault_en", 64'(bus.fault_en_o), 64'd0);
            check("abort_err_valid", 64'(bus.err_valid), 64'd0);
            check("abort_inj_cnt", 64'(bus.inj_cnt), 64'(inj));
            check("abort_err_cnt", 64'(bus.err_cnt), 64'(err));
            seen = 0;
            repeat (40) begin
               @(negedge CLK);
               if (bus.done || bus.busy) seen++;
            end
            check("abort_quiet", 64'(seen), 64'd0);
            return;
         end
         if (j == rst_at) begin
            RSTB = 1'b0;
            #1;
            check("reset_async_outs", all_outs(), 64'd0);
            @(negedge CLK);
            RSTB = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      logic [15:0] inj_hold;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_outs", all_outs(), 64'd0);
      RSTB = 1'b1;
      @(negedge CLK);
      check("idle_after_reset", all_outs(), 64'd0);

      run(0, -1, 200 + $urandom_range(0, 400), -1);
      run(1, -1, -1, -1);
      run(2, -1, -1, -1);
      run(3, -1, -1, -1);
      run(3, -1, $urandom_range(1, NCYC - 2), -1);
      run(3, 3 * VBLK + $urandom_range(0, VBLK - 1), -1, -1);
      run(3, -1, -1, -1);

      // start and abort together in IDLE: abort wins
      inj_hold = bus.inj_cnt;
      @(negedge CLK);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge CLK);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("start_abort_busy", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge CLK);
      check("start_abort_still_idle", 64'({bus.busy, bus.fault_en_o}), 64'd0);
      check("start_abort_cnt_hold", 64'(bus.inj_cnt), 64'(inj_hold));

      run(3, -1, -1, 400);
      @(negedge CLK);
      check("idle_after_midrun_reset", all_outs(), 64'd0);
      run(2, -1, -1, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
